decode_stage: RTL
=================

# decode_stage

Registered, back-pressured LEGv8 instruction-decode pipeline stage. It sits between fetch and execute: it accepts one 32-bit instruction per valid/ready handshake and emits a registered control/immediate bundle one cycle later. It owns the architectural NZCV flag register and resolves B.cond in decode, covering all 15 conditions. It stalls on load-use hazards and on B.cond while a flag-setting instruction is still in flight.

## Interface
- DATA_W, 64: width of the sign/zero-extended immediate output.
- MAX_FLAG_PEND, 3: maximum number of issued, uncommitted flag-setting instructions (ADDS/SUBS).
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- in_valid / in_ready  in / out  1 / 1  upstream handshake; transfer when both are high.
- instruction  in  32  instruction word, stable while in_valid is high.
- flags_in  in  4  NZCV from execute, as {N,Z,C,V}.
- flags_we  in  1  execute commits flags_in this cycle; one per issued ADDS/SUBS.
- out_valid / out_ready  out / in  1 / 1  downstream handshake.
- Rd, Rn, Rm  out  5 each  instr[4:0], [9:5], [20:16].
- UncondBr, BrTaken, CbzBr, Reg2Loc, RegWrite, ALUSrc, MemWrite, MemToReg, ByteOrFull, SetFlags, ImmInstr, Mov, Clear, Illegal  out  1 each  decoded controls.
- ALUOp  out  3  010 add, 011 sub, 000 pass-B.
- shamt  out  2  instr[22:21], MOVZ/MOVK only; 0 otherwise.
- Imm  out  DATA_W  extended immediate.

## Operation
- Opcode match order, first hit wins:
  - B: instr[31:26]=000101.
  - B.cond 01010100 and CBZ 10110100: instr[31:24].
  - ADDS 10101011000, SUBS 11101011000, STURB 00111000000, LDURB 00111000010, STUR 11111000000, LDUR 11111000010: instr[31:21].
  - ADDI 1001000100: instr[31:22].
  - MOVZ 110100101, MOVK 111100101: instr[31:23].
  - Anything else is Illegal=1 with all write/branch controls 0.
- Controls per instruction:
  - B: UncondBr=1, BrTaken=1.
  - B.cond: BrTaken = cond(instr[3:0], flag_q). Codes EQ0 NE1 HS2 LO3 MI4 PL5 VS6 VC7 HI8 LS9 GE10 LT11 GT12 LE13 AL14; code 15 → Illegal.
  - CBZ: CbzBr=1, Reg2Loc=0, ALUOp=000; execute resolves the branch.
  - ADDS/SUBS: Reg2Loc=1, RegWrite=1, SetFlags=1, ALUOp=010/011.
  - ADDI: ALUSrc=1, RegWrite=1, ImmInstr=1, ALUOp=010.
  - LDUR/LDURB: ALUSrc=1, RegWrite=1, MemToReg=1, ALUOp=010; ByteOrFull=1 for the B variant.
  - STUR/STURB: Reg2Loc=0, ALUSrc=1, MemWrite=1, RegWrite=0, ALUOp=010; ByteOrFull=1 for the B variant.
  - MOVZ/MOVK: Mov=1, RegWrite=1; Clear=1 for MOVZ only.
  - Unlisted controls are 0; no X outputs.
- Imm values:
  - ADDI: zero-extended instr[21:10].
  - D-type: sign-extended instr[20:12].
  - CBZ/B.cond: sign-extended instr[23:5].
  - B: sign-extended instr[25:0].
  - MOV: zero-extended instr[20:5].
  - Otherwise 0.
- Flag register flag_q: loads flags_in when flags_we is high.
- Pending counter pend (0..MAX_FLAG_PEND):
  - +1 on an accepted ADDS/SUBS, −1 on flags_we; both in the same cycle leaves it unchanged.
  - flags_we with pend=0 still updates flag_q; pend stays 0.
- Hazards, evaluated on the incoming instruction:
  - load_use: output register holds a valid LDUR/LDURB whose Rd≠31 equals the incoming Rn, or the incoming Rm when Reg2Loc=1, or the incoming Rd for STUR/STURB/CBZ.
  - cond_wait: incoming is B.cond and pend≠0.
  - pend_full: incoming is ADDS/SUBS and pend=MAX_FLAG_PEND.
- in_ready = (!out_valid | out_ready) & !(load_use | cond_wait | pend_full).
- Output register:
  - Loads the decoded bundle on an input transfer.
  - Otherwise, when out_ready is high, drops out_valid to 0, emitting a bubble.
  - Holds all outputs while out_valid & !out_ready.

## Timing
- Latency: 1 cycle, input transfer → out_valid.
- Throughput: 1 instruction per cycle absent hazards.
- Load-use costs exactly one bubble.
- B.cond issues the cycle after the last pending flags_we and uses the updated flag_q.
- Reset, asynchronous: out_valid=0, every control output 0, ALUOp=000, Imm=0, Rd/Rn/Rm=0, shamt=0, flag_q=0000, pend=0. in_ready=1 the first cycle after reset deasserts.
- Reset mid-stall discards the held instruction; upstream must re-present it.
- out_ready=0 with out_valid=0 still accepts: the register is empty.

## Test plan
- ADDI X1,X0,#5 (0x910014_01) then ADDS X2,X1,X1 → out_valid one cycle after each; ADDI Imm=5, ALUOp=010; ADDS SetFlags=1, pend=1.
- SUBS then B.LT with flags_we 3 cycles later carrying N=1,V=0 → B.LT held (in_ready=0) 3 cycles, then issues next cycle with BrTaken=1.
- LDUR X3,[X0,#-8] then ADD using Rn=3 → one bubble (out_valid=0 for one cycle), then the ADD issues. Same pair with Rd=31 → no bubble. LDUR Imm is all ones minus 7 (0xFFFF_FFFF_FFFF_FFF8).
- 4 back-to-back ADDS, no flags_we → 4th stalls at pend=3; a flags_we pulse releases it the next cycle.
- out_ready=0 for 5 cycles with in_valid=1 → outputs hold stable, exactly one instruction buffered, no loss or duplication.
- Opcode 0x00000000 → Illegal=1, RegWrite=MemWrite=BrTaken=0. Assert reset mid-stream → all outputs 0 asynchronously, flag_q=0.

Source files
------------

// File: rtl/decode_stage.sv
// LEGv8 decode stage: decodes one instruction into a registered control/immediate bundle and owns the NZCV flags.
// Latency: 1 cycle from input transfer to out_valid; 1 instruction per cycle absent hazards.
// Backpressure: in_ready drops when the output register is full and not draining, or on load-use / flag hazards.
module decode_stage #(
   parameter int DATA_W        = 64,
   parameter int MAX_FLAG_PEND = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [31:0]       instruction,
   input  logic [3:0]        flags_in,
   input  logic              flags_we,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [4:0]        Rd,
   output logic [4:0]        Rn,
   output logic [4:0]        Rm,
   output logic              UncondBr,
   output logic              BrTaken,
   output logic              CbzBr,
   output logic              Reg2Loc,
   output logic              RegWrite,
   output logic              ALUSrc,
   output logic              MemWrite,
   output logic              MemToReg,
   output logic              ByteOrFull,
   output logic              SetFlags,
   output logic              ImmInstr,
   output logic              Mov,
   output logic              Clear,
   output logic              Illegal,
   output logic [2:0]        ALUOp,
   output logic [1:0]        shamt,
   output logic [DATA_W-1:0] Imm
);

   localparam int PW = $clog2(MAX_FLAG_PEND + 1);
   localparam logic [PW-1:0] PEND_MAX = PW'(MAX_FLAG_PEND);

   localparam logic [10:0] OP_ADDS  = 11'b10101011000;
   localparam logic [10:0] OP_SUBS  = 11'b11101011000;
   localparam logic [10:0] OP_STURB = 11'b00111000000;
   localparam logic [10:0] OP_LDURB = 11'b00111000010;
   localparam logic [10:0] OP_STUR  = 11'b11111000000;
   localparam logic [10:0] OP_LDUR  = 11'b11111000010;

   localparam logic [2:0] ALU_PASSB = 3'b000;
   localparam logic [2:0] ALU_ADD   = 3'b010;
   localparam logic [2:0] ALU_SUB   = 3'b011;

   logic [3:0]    flag_q;
   logic [PW-1:0] pend;

   logic [10:0] op11;
   logic        n_f, z_f, c_f, v_f;
   logic        cond_true;

   logic              d_uncond, d_brtaken, d_cbz, d_reg2loc, d_regwrite, d_alusrc;
   logic              d_memwrite, d_memtoreg, d_byte, d_setflags, d_imminstr;
   logic              d_mov, d_clear, d_illegal, d_bcond, d_uses_rd;
   logic [2:0]        d_aluop;
   logic [1:0]        d_shamt;
   logic [DATA_W-1:0] d_imm;

   logic load_use, cond_wait, pend_full, accept;

   assign op11 = instruction[31:21];
   assign {n_f, z_f, c_f, v_f} = flag_q;

   // B.cond evaluation against the committed flags
   always_comb begin
      cond_true = 1'b0;
      case (instruction[3:0])
         4'd0:    cond_true = z_f;
         4'd1:    cond_true = !z_f;
         4'd2:    cond_true = c_f;
         4'd3:    cond_true = !c_f;
         4'd4:    cond_true = n_f;
         4'd5:    cond_true = !n_f;
         4'd6:    cond_true = v_f;
         4'd7:    cond_true = !v_f;
         4'd8:    cond_true = c_f & !z_f;
         4'd9:    cond_true = !(c_f & !z_f);
         4'd10:   cond_true = (n_f == v_f);
         4'd11:   cond_true = (n_f != v_f);
         4'd12:   cond_true = !z_f & (n_f == v_f);
         4'd13:   cond_true = !(!z_f & (n_f == v_f));
         4'd14:   cond_true = 1'b1;
         default: cond_true = 1'b0;
      endcase
   end

   // Opcode decode, first match wins
   always_comb begin
      d_uncond   = 1'b0;
      d_brtaken  = 1'b0;
      d_cbz      = 1'b0;
      d_reg2loc  = 1'b0;
      d_regwrite = 1'b0;
      d_alusrc   = 1'b0;
      d_memwrite = 1'b0;
      d_memtoreg = 1'b0;
      d_byte     = 1'b0;
      d_setflags = 1'b0;
      d_imminstr = 1'b0;
      d_mov      = 1'b0;
      d_clear    = 1'b0;
      d_illegal  = 1'b0;
      d_bcond    = 1'b0;
      d_uses_rd  = 1'b0;
      d_aluop    = ALU_PASSB;
      d_shamt    = 2'b00;
      d_imm      = '0;
      if (instruction[31:26] == 6'b000101) begin
         d_uncond  = 1'b1;
         d_brtaken = 1'b1;
         d_imm     = {{(DATA_W-26){instruction[25]}}, instruction[25:0]};
      end else if (instruction[31:24] == 8'b01010100) begin
         d_bcond = 1'b1;
         d_imm   = {{(DATA_W-19){instruction[23]}}, instruction[23:5]};
         if (instruction[3:0] == 4'hF) d_illegal = 1'b1;
         else                          d_brtaken = cond_true;
      end else if (instruction[31:24] == 8'b10110100) begin
         d_cbz     = 1'b1;
         d_uses_rd = 1'b1;
         d_imm     = {{(DATA_W-19){instruction[23]}}, instruction[23:5]};
      end else if (op11 == OP_ADDS || op11 == OP_SUBS) begin
         d_reg2loc  = 1'b1;
         d_regwrite = 1'b1;
         d_setflags = 1'b1;
         d_aluop    = (op11 == OP_SUBS) ? ALU_SUB : ALU_ADD;
      end else if (op11 == OP_LDUR || op11 == OP_LDURB) begin
         d_alusrc   = 1'b1;
         d_regwrite = 1'b1;
         d_memtoreg = 1'b1;
         d_byte     = (op11 == OP_LDURB);
         d_aluop    = ALU_ADD;
         d_imm      = {{(DATA_W-9){instruction[20]}}, instruction[20:12]};
      end else if (op11 == OP_STUR || op11 == OP_STURB) begin
         d_alusrc   = 1'b1;
         d_memwrite = 1'b1;
         d_uses_rd  = 1'b1;
         d_byte     = (op11 == OP_STURB);
         d_aluop    = ALU_ADD;
         d_imm      = {{(DATA_W-9){instruction[20]}}, instruction[20:12]};
      end else if (instruction[31:22] == 10'b1001000100) begin
         d_alusrc   = 1'b1;
         d_regwrite = 1'b1;
         d_imminstr = 1'b1;
         d_aluop    = ALU_ADD;
         d_imm      = {{(DATA_W-12){1'b0}}, instruction[21:10]};
      end else if (instruction[31:23] == 9'b110100101 || instruction[31:23] == 9'b111100101) begin
         d_mov      = 1'b1;
         d_regwrite = 1'b1;
         d_clear    = (instruction[31:23] == 9'b110100101);
         d_shamt    = instruction[22:21];
         d_imm      = {{(DATA_W-16){1'b0}}, instruction[20:5]};
      end else begin
         d_illegal = 1'b1;
      end
   end

   // Hazards against the instruction currently presented upstream
   always_comb begin
      load_use  = out_valid & MemToReg & (Rd != 5'd31) &
                  ((Rd == instruction[9:5]) |
                   (d_reg2loc & (Rd == instruction[20:16])) |
                   (d_uses_rd & (Rd == instruction[4:0])));
      cond_wait = d_bcond & (pend != '0);
      pend_full = d_setflags & (pend == PEND_MAX);
      in_ready  = (!out_valid | out_ready) & !(load_use | cond_wait | pend_full);
   end

   assign accept = in_valid & in_ready;

   // Flag register and in-flight flag-setter count
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         flag_q <= 4'b0000;
         pend   <= '0;
      end else begin
         if (flags_we) flag_q <= flags_in;
         if (accept & d_setflags) begin
            if (!flags_we) pend <= pend + 1'b1;
         end else if (flags_we && pend != '0) begin
            pend <= pend - 1'b1;
         end
      end
   end

   // Output register: load on transfer, bubble when drained, hold when stalled
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_valid  <= 1'b0;
         Rd         <= 5'd0;
         Rn         <= 5'd0;
         Rm         <= 5'd0;
         UncondBr   <= 1'b0;
         BrTaken    <= 1'b0;
         CbzBr      <= 1'b0;
         Reg2Loc    <= 1'b0;
         RegWrite   <= 1'b0;
         ALUSrc     <= 1'b0;
         MemWrite   <= 1'b0;
         MemToReg   <= 1'b0;
         ByteOrFull <= 1'b0;
         SetFlags   <= 1'b0;
         ImmInstr   <= 1'b0;
         Mov        <= 1'b0;
         Clear      <= 1'b0;
         Illegal    <= 1'b0;
         ALUOp      <= ALU_PASSB;
         shamt      <= 2'b00;
         Imm        <= '0;
      end else if (accept) begin
         out_valid  <= 1'b1;
         Rd         <= instruction[4:0];
         Rn         <= instruction[9:5];
         Rm         <= instruction[20:16];
         UncondBr   <= d_uncond;
         BrTaken    <= d_brtaken;
         CbzBr      <= d_cbz;
         Reg2Loc    <= d_reg2loc;
         RegWrite   <= d_regwrite;
         ALUSrc     <= d_alusrc;
         MemWrite   <= d_memwrite;
         MemToReg   <= d_memtoreg;
         ByteOrFull <= d_byte;
         SetFlags   <= d_setflags;
         ImmInstr   <= d_imminstr;
         Mov        <= d_mov;
         Clear      <= d_clear;
         Illegal    <= d_illegal;
         ALUOp      <= d_aluop;
         shamt      <= d_shamt;
         Imm        <= d_imm;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule
